slave_b_resp_buffer: RTL and testbench
======================================

# slave_b_resp_buffer

Buffers write responses from the two-source B-channel response mux (error and posted responses) and drives the AXI4 slave B channel toward the external master with a full VALID/READY handshake. The mux upstream has no backpressure. This block therefore provides DEPTH entries of storage and a full indication, which the response sources use to stall. It sits directly downstream of the write-response mux, and is the last stage before the AXI B-channel pins.

## Interface
Parameters:
- ID_WIDTH, 4, width of BID / in_bid
- RESP_WIDTH, 2, width of BRESP / in_bresp
- DEPTH, 4, response entries; power of two, minimum 2

Ports:
- ACLK  in  1  clock; all logic on rising edge
- ARESET  in  1  reset, asynchronous, active-high
- in_bvalid  in  1  response present from mux (one push per cycle high)
- in_bresp  in  RESP_WIDTH  response code from mux
- in_bid  in  ID_WIDTH  transaction ID from mux
- in_full  out  1  buffer full; sources must not assert in_bvalid
- BVALID  out  1  AXI B valid to master
- BRESP  out  RESP_WIDTH  AXI B response
- BID  out  ID_WIDTH  AXI B ID
- BREADY  in  1  AXI B ready from master
- occupancy  out  $clog2(DEPTH)+1  entries currently stored
- overflow_err  out  1  sticky: push attempted while full

## Operation
- Circular FIFO: storage mem[DEPTH] of {bresp, bid}; wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0; count is $clog2(DEPTH)+1 bits.
- push = in_bvalid && !in_full.
  - On push: mem[wr_ptr] <= {in_bresp, in_bid}; wr_ptr++.
- pop = BVALID && BREADY.
  - On pop: rd_ptr++.
- count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on push+pop in the same cycle, or when neither occurs.
- in_full = (count == DEPTH).
  - A push attempt while full is dropped, even if a pop occurs the same cycle: in_full is evaluated on the pre-edge count.
- overflow_err: set to 1 on (in_bvalid && in_full); cleared only by ARESET.
- Head presentation is first-word-fall-through:
  - BVALID = (count != 0).
  - BRESP/BID = mem[rd_ptr].
  - When empty, BRESP/BID are driven to 0.
- AXI stability: once BVALID is high, BVALID, BRESP and BID hold until the cycle BREADY is sampled high. The head changes only on pop; pushes never disturb the head entry.
- occupancy = count.
- Ordering is strict FIFO. Error and posted responses leave in arrival order, with no reordering by ID.

## Timing
- Reset (ARESET high, asynchronous assert): wr_ptr=0, rd_ptr=0, count=0, overflow_err=0 → BVALID=0, BRESP=0, BID=0, in_full=0, occupancy=0. Memory contents are don't-care.
- Reset mid-operation: all stored responses are discarded, and outputs reach reset values without waiting for a clock edge. Release is synchronous to ACLK by the system reset synchronizer.
- Latency: a push at edge N makes BVALID high after edge N when the buffer was empty. Minimum in-to-out latency is 1 cycle; there is no combinational path from in_* to B outputs.
- Throughput: 1 response/cycle sustained with BREADY held high, and count remains constant.
- in_full rises after the edge that stores the DEPTH-th entry. It falls after the edge of the first pop.
- BREADY high while BVALID low: no effect.
- Combinational outputs: BVALID, BRESP, BID, in_full and occupancy all derive from registers only.

## Test plan
- Reset/idle: assert ARESET mid-stream with 2 entries stored → BVALID=0, BID=0, occupancy=0, in_full=0 immediately; after release, BREADY=1 produces no B transfers.
- Single response: push {bresp=2'b10, bid=4'h3} with BREADY=1 → BVALID=1, BRESP=2'b10, BID=3 exactly one cycle later for one cycle; occupancy returns to 0.
- Fill and backpressure: BREADY=0, push IDs 1,2,3,4 → in_full=1 and occupancy=4 after the 4th edge. Then BREADY=1 → BIDs 1,2,3,4 emerge in order on consecutive cycles, and BVALID/BID hold stable while BREADY=0.
- Overflow: with the buffer full, assert in_bvalid with bid=4'hF while BREADY=1 → the entry is not stored, overflow_err=1 and stays 1, and the output ID sequence contains no 4'hF.
- Simultaneous push/pop: with occupancy=2 and BREADY=1, push continuously for 10 cycles with IDs 0..9 → occupancy stays 2, and output IDs follow input order without loss.
- Pointer wrap: run 3×DEPTH+1 responses with random BREADY stalls → every ID is received exactly once in order; no duplicate and no skip at the DEPTH-1 → 0 pointer wrap.

Source files
------------

// File: rtl/slave_b_resp_buffer_if.sv
// Write-response path between the B-channel mux, the response buffer and the AXI B pins.
// The buffer uses the slave modport. The environment that drives the mux side and BREADY uses the master modport.
interface slave_b_resp_buffer_if #(
   parameter int ID_WIDTH   = 4,
   parameter int RESP_WIDTH = 2
) ();
   logic                  in_bvalid;
   logic [RESP_WIDTH-1:0] in_bresp;
   logic [ID_WIDTH-1:0]   in_bid;
   logic                  in_full;
   logic                  BVALID;
   logic [RESP_WIDTH-1:0] BRESP;
   logic [ID_WIDTH-1:0]   BID;
   logic                  BREADY;

   modport slave (
      input  in_bvalid, in_bresp, in_bid, BREADY,
      output in_full, BVALID, BRESP, BID
   );

   modport master (
      output in_bvalid, in_bresp, in_bid, BREADY,
      input  in_full, BVALID, BRESP, BID
   );
endinterface

// File: rtl/slave_b_resp_buffer.sv
// A first-word-fall-through FIFO that holds write responses coming from the B mux, which has no backpressure.
// It drives the AXI B channel, and it asserts in_full so that the response sources stall.
module slave_b_resp_buffer #(
   parameter int ID_WIDTH   = 4,
   parameter int RESP_WIDTH = 2,
   parameter int DEPTH      = 4
) (
   input  logic                     ACLK,
   input  logic                     ARESET,
   slave_b_resp_buffer_if.slave     bus,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic                     overflow_err
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [RESP_WIDTH-1:0] bresp;
      logic [ID_WIDTH-1:0]   bid;
   } entry_t;

   entry_t             mem [DEPTH];
   entry_t             head;
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               push;
   logic               pop;

   // A push is judged against the count before the edge, so a pop in the same cycle cannot make room for it.
   assign push = bus.in_bvalid && !bus.in_full;
   assign pop  = bus.BVALID && bus.BREADY;

   assign bus.in_full = (count == CNT_W'(DEPTH));
   assign bus.BVALID  = (count != '0);
   assign head        = bus.BVALID ? mem[rd_ptr] : '0;
   assign bus.BRESP   = head.bresp;
   assign bus.BID     = head.bid;
   assign occupancy   = count;

   // NOTE: storage has no reset; the valid state lives entirely in count/pointers.
   always_ff @(posedge ACLK) begin
      if (push) begin
         mem[wr_ptr] <= '{bresp: bus.in_bresp, bid: bus.in_bid};
      end
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         overflow_err <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (bus.in_bvalid && bus.in_full) begin
            overflow_err <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_slave_b_resp_buffer.sv
// Directed bench for slave_b_resp_buffer. It covers reset, single transfer, fill/backpressure, overflow,
// concurrent push/pop, pointer wrap, and reset applied in mid-stream.
module tb_slave_b_resp_buffer;
   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] occupancy;
   logic       overflow_err;

   int total = 0;
   int bad   = 0;

   logic [3:0] recv_q [$];
   logic [3:0] exp_q  [$];
   logic       hold_prev;
   logic [3:0] prev_id;
   logic [1:0] prev_resp;

   slave_b_resp_buffer_if #(.ID_WIDTH(4), .RESP_WIDTH(2)) bus ();

   slave_b_resp_buffer #(.ID_WIDTH(4), .RESP_WIDTH(2), .DEPTH(4)) dut (
      .ACLK         (clk),
      .ARESET       (rst),
      .bus          (bus),
      .occupancy    (occupancy),
      .overflow_err (overflow_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] r, input logic [3:0] id);
      bus.in_bvalid = v;
      bus.in_bresp  = r;
      bus.in_bid    = id;
   endtask

   task automatic check_recv(input string tag);
      check({tag, "_count"}, recv_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < recv_q.size(); i++) begin
         check($sformatf("%s_id%0d", tag, i), recv_q[i], exp_q[i]);
      end
      recv_q.delete();
      exp_q.delete();
   endtask

   // Inputs change just after posedge, so the B handshake is stable at negedge and is recorded there.
   always @(negedge clk) begin
      if (rst) begin
         hold_prev <= 1'b0;
      end else begin
         if (hold_prev) begin
            check("hold_valid", bus.BVALID, 1);
            check("hold_id", bus.BID, prev_id);
            check("hold_resp", bus.BRESP, prev_resp);
         end
         if (bus.BVALID && bus.BREADY) recv_q.push_back(bus.BID);
         hold_prev <= bus.BVALID && !bus.BREADY;
         prev_id   <= bus.BID;
         prev_resp <= bus.BRESP;
      end
   end

   initial begin
      int sent;
      int cycles;

      rst        = 1'b1;
      bus.BREADY = 1'b0;
      drive(1'b0, 2'b00, 4'h0);
      repeat (2) tick();
      check("rst_valid", bus.BVALID, 0);
      check("rst_bid", bus.BID, 0);
      check("rst_bresp", bus.BRESP, 0);
      check("rst_full", bus.in_full, 0);
      check("rst_occ", occupancy, 0);
      check("rst_ovf", overflow_err, 0);
      rst = 1'b0;
      tick();

      // Single response: visible one cycle after the push edge, for exactly one cycle.
      bus.BREADY = 1'b1;
      drive(1'b1, 2'b10, 4'h3);
      tick();
      drive(1'b0, 2'b00, 4'h0);
      check("single_valid", bus.BVALID, 1);
      check("single_resp", bus.BRESP, 2'b10);
      check("single_id", bus.BID, 4'h3);
      check("single_occ", occupancy, 1);
      tick();
      check("single_valid_low", bus.BVALID, 0);
      check("single_empty_id", bus.BID, 0);
      check("single_occ_end", occupancy, 0);
      exp_q.push_back(4'h3);
      check_recv("single");

      // Fill under backpressure.
      bus.BREADY = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 2'b00, 4'(i));
         tick();
         check($sformatf("fill_occ%0d", i), occupancy, i);
         check($sformatf("fill_full%0d", i), bus.in_full, (i == 4));
      end
      drive(1'b0, 2'b00, 4'h0);
      repeat (2) tick();
      check("fill_head", bus.BID, 4'h1);
      check("fill_occ_hold", occupancy, 4);

      // Overflow: push of 0xF while full is dropped even though a pop happens that cycle.
      bus.BREADY = 1'b1;
      drive(1'b1, 2'b11, 4'hF);
      tick();
      drive(1'b0, 2'b00, 4'h0);
      check("ovf_flag", overflow_err, 1);
      check("ovf_occ", occupancy, 3);
      check("ovf_full_fall", bus.in_full, 0);
      check("ovf_head", bus.BID, 4'h2);
      repeat (3) tick();
      check("ovf_drain_occ", occupancy, 0);
      check("ovf_sticky", overflow_err, 1);
      for (int i = 1; i <= 4; i++) exp_q.push_back(4'(i));
      check_recv("fill");

      // Simultaneous push/pop at occupancy 2.
      bus.BREADY = 1'b0;
      drive(1'b1, 2'b01, 4'hA);
      tick();
      drive(1'b1, 2'b01, 4'hB);
      tick();
      check("sim_occ_start", occupancy, 2);
      bus.BREADY = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 2'b00, 4'(i));
         tick();
         check($sformatf("sim_occ%0d", i), occupancy, 2);
      end
      drive(1'b0, 2'b00, 4'h0);
      repeat (2) tick();
      check("sim_occ_end", occupancy, 0);
      exp_q.push_back(4'hA);
      exp_q.push_back(4'hB);
      for (int i = 0; i < 10; i++) exp_q.push_back(4'(i));
      check_recv("sim");

      // Pointer wrap with random BREADY stalls: 3*DEPTH+1 responses.
      sent   = 0;
      cycles = 0;
      while ((sent < 13 || occupancy != 0) && cycles < 400) begin
         bus.BREADY = 1'($urandom_range(0, 1));
         if (sent < 13 && !bus.in_full) begin
            drive(1'b1, 2'b00, sent[3:0]);
            sent++;
         end else begin
            drive(1'b0, 2'b00, 4'h0);
         end
         tick();
         cycles++;
      end
      drive(1'b0, 2'b00, 4'h0);
      bus.BREADY = 1'b0;
      check("wrap_in_time", (cycles < 400), 1);
      for (int i = 0; i < 13; i++) exp_q.push_back(4'(i));
      check_recv("wrap");

      // Reset in mid-stream with two entries stored; outputs clear without a clock edge.
      drive(1'b1, 2'b00, 4'h5);
      tick();
      drive(1'b1, 2'b00, 4'h6);
      tick();
      drive(1'b0, 2'b00, 4'h0);
      check("mid_occ_pre", occupancy, 2);
      #2;
      rst = 1'b1;
      #1;
      check("mid_valid", bus.BVALID, 0);
      check("mid_bid", bus.BID, 0);
      check("mid_occ", occupancy, 0);
      check("mid_full", bus.in_full, 0);
      check("mid_ovf", overflow_err, 0);
      tick();
      rst        = 1'b0;
      bus.BREADY = 1'b1;
      repeat (4) tick();
      check("post_rst_valid", bus.BVALID, 0);
      check_recv("post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
